fc_word_aligner: RTL

FC_WORD_ALIGNER -- requirements
Module: fc_word_aligner

---
 rtl/fc_pkg.sv | 18 +
 rtl/fc_comma_detect.sv | 35 +++
 rtl/fc_word_aligner.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared constants and types for the Fibre Channel word aligner.
// K28.5 comma codes in line order, plus the alignment FSM state type.
package fc;

    localparam logic [9:0] K28_5_RDN = 10'h0FA;
    localparam logic [9:0] K28_5_RDP = 10'h305;

    typedef enum logic [1:0] {
        StHunt,
        StVerify,
        StLocked
    } align_state_e;

    function automatic logic is_comma(input logic [9:0] sym);
        return (sym == K28_5_RDN) || (sym == K28_5_RDP);
    endfunction

endpackage

// File: rtl/fc_comma_detect.sv
// Combinational K28.5 search over a two-word window.
// Produces a per-offset match vector and the lowest matching offset.
module fc_comma_detect
    import fc::*;
#(
    parameter int unsigned SYMBOLS = 4
) (
    input  logic [20*SYMBOLS-1:0]         window,
    output logic [10*SYMBOLS-1:0]         match,
    output logic                          found,
    output logic [$clog2(10*SYMBOLS)-1:0] first_offset
);

    localparam int unsigned W  = 10 * SYMBOLS;
    localparam int unsigned OW = $clog2(W);

    always_comb begin
        match = '0;
        for (int o = 0; o < int'(W); o++) begin
            match[o] = is_comma(window[o +: 10]);
        end
    end

    // Scan downwards so the lowest matching offset is the one left standing.
    always_comb begin
        found        = |match;
        first_offset = '0;
        for (int o = int'(W) - 1; o >= 0; o--) begin
            if (match[o]) begin
                first_offset = OW'(o);
            end
        end
    end

endmodule

// File: rtl/fc_word_aligner.sv
// Comma-based word aligner: two-word window, barrel shifter and HUNT/VERIFY/LOCKED FSM.
// Window register stage followed by a registered, aligned output stage.
module fc_word_aligner
    import fc::*;
#(
    parameter int unsigned SYMBOLS    = 4,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned LOSS_COUNT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [10*SYMBOLS-1:0]         in_data,
    input  logic                          in_valid,
    output logic [10*SYMBOLS-1:0]         out_data,
    output logic                          out_valid,
    output logic [SYMBOLS-1:0]            out_comma,
    output logic                          locked,
    output logic [$clog2(10*SYMBOLS)-1:0] offset,
    output logic [15:0]                   realign_count
);

    localparam int unsigned W  = 10 * SYMBOLS;
    localparam int unsigned OW = $clog2(W);

    logic [W-1:0]   cur_q;
    logic [W-1:0]   prev_q;
    logic           s1_valid_q;
    logic [2*W-1:0] window;

    logic [W-1:0]   match;
    logic           found;
    logic [OW-1:0]  first_offset;

    align_state_e   state_q;
    logic [OW-1:0]  offset_q;
    logic [3:0]     good_q;
    logic [3:0]     bad_q;
    logic [15:0]    realign_q;

    logic [W-1:0]       aligned;
    logic [SYMBOLS-1:0] sym_comma;
    logic               at_latched;
    logic [3:0]         good_next;
    logic [3:0]         bad_next;
    logic               enter_lock;
    logic               drop_lock;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q      <= '0;
            prev_q     <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                cur_q  <= in_data;
                prev_q <= cur_q;
            end
        end
    end

    assign window = {cur_q, prev_q};

    fc_comma_detect #(
        .SYMBOLS(SYMBOLS)
    ) u_detect (
        .window      (window),
        .match       (match),
        .found       (found),
        .first_offset(first_offset)
    );

    // Shift uses the offset held before this word updates the FSM.
    assign aligned = W'(window >> offset_q);

    always_comb begin
        sym_comma = '0;
        for (int i = 0; i < int'(SYMBOLS); i++) begin
            sym_comma[i] = is_comma(aligned[10*i +: 10]);
        end
    end

    always_comb begin
        at_latched = match[offset_q];
        good_next  = good_q + 4'd1;
        bad_next   = bad_q + 4'd1;
        enter_lock = found && (((state_q == StHunt) && (LOCK_COUNT == 1)) ||
                               ((state_q == StVerify) && at_latched &&
                                (good_next == 4'(LOCK_COUNT))));
        drop_lock  = found && (state_q == StLocked) && !at_latched &&
                     (bad_next == 4'(LOSS_COUNT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StHunt;
            offset_q  <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            realign_q <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_comma <= '0;
        end else if (s1_valid_q) begin
            out_data  <= aligned;
            out_comma <= sym_comma;
            // The word that drops lock still leaves with out_valid high.
            out_valid <= (state_q == StLocked) || enter_lock;
            if (found) begin
                case (state_q)
                    StHunt: begin
                        offset_q <= first_offset;
                        good_q   <= 4'd1;
                        bad_q    <= '0;
                        state_q  <= (LOCK_COUNT == 1) ? StLocked : StVerify;
                    end
                    StVerify: begin
                        if (at_latched) begin
                            good_q <= good_next;
                            if (enter_lock) begin
                                state_q <= StLocked;
                                bad_q   <= '0;
                            end
                        end else begin
                            offset_q <= first_offset;
                            good_q   <= 4'd1;
                        end
                    end
                    StLocked: begin
                        if (at_latched) begin
                            bad_q <= '0;
                        end else if (drop_lock) begin
                            state_q <= StHunt;
                            bad_q   <= '0;
                            good_q  <= '0;
                            if (realign_q != 16'hFFFF) begin
                                realign_q <= realign_q + 16'd1;
                            end
                        end else begin
                            bad_q <= bad_next;
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

    assign locked        = (state_q == StLocked);
    assign offset        = offset_q;
    assign realign_count = realign_q;

endmodule
